michael_bell_hovalaag: RTL and testbench

Compact 12-bit accumulator-style CPU inspired by the HOVALAAG puzzle machine, packaged as a Tiny Tapeout user tile. The program is not stored on chip. An external host streams each 32-bit instruction plus one 12-bit input word over four clock phases. The host reads back the program counter, status and a 12-bit output register on the same pins.

---
 rtl/michael_bell_hovalaag_if.sv | 21 ++
 rtl/michael_bell_hovalaag.sv | 175 +++++++++++++++++
 tb/tb_michael_bell_hovalaag.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/michael_bell_hovalaag_if.sv
// Pin bundle of the HOVALAAG tile: host drives enable and the 12-bit data word,
// the tile returns the multiplexed 12-bit readback plus its current phase.
interface michael_bell_hovalaag_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [1:0] phase;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe, phase
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe, phase
    );
endinterface

// File: rtl/michael_bell_hovalaag.sv
// 12-bit accumulator CPU with an externally streamed program: each 32-bit
// instruction arrives over phases 0..2 and executes on the edge leaving phase 3.
module michael_bell_hovalaag (
    input logic                    clk,
    input logic                    rst,
    michael_bell_hovalaag_if.slave bus
);
    typedef enum logic [1:0] {PH0 = 2'd0, PH1 = 2'd1, PH2 = 2'd2, PH3 = 2'd3} phase_t;

    phase_t      ph, ph_next;
    logic [11:0] a, b, c, d, out_reg;
    logic        f, out_strobe, in_read;
    logic [7:0]  pc;
    logic [11:0] instr_lo, instr_mid;
    logic [7:0]  instr_hi;

    logic [31:0] instr;
    logic [11:0] in_word;
    logic [11:0] out_word;
    logic        unused_ok;

    assign in_word   = {bus.uio_in[3:0], bus.ui_in};
    assign instr     = {instr_hi, instr_mid, instr_lo};
    assign unused_ok = &{1'b0, bus.uio_in[7:4]};

    // Instruction fields
    logic [3:0] alu_op;
    logic [1:0] a_src, b_src, c_src, out_src;
    logic       d_src;
    logic [2:0] pc_op;
    logic [11:0] k;
    logic [7:0]  l;

    assign alu_op  = instr[31:28];
    assign a_src   = instr[27:26];
    assign b_src   = instr[25:24];
    assign c_src   = instr[23:22];
    assign d_src   = instr[21];
    assign out_src = instr[20:19];
    assign pc_op   = instr[18:16];
    assign k       = {4'h0, instr[15:8]};
    assign l       = instr[7:0];

    // Phase FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ph <= PH0;
        else     ph <= ph_next;
    end

    // Phase FSM: next state
    always_comb begin
        ph_next = ph;
        if (bus.ena) begin
            case (ph)
                PH0:     ph_next = PH1;
                PH1:     ph_next = PH2;
                PH2:     ph_next = PH3;
                default: ph_next = PH0;
            endcase
        end
    end

    // Phase FSM: outputs (readback mux)
    always_comb begin
        out_word = out_reg;
        case (ph)
            PH0:     out_word = {4'h0, pc};
            PH1:     out_word = {9'b0, in_read, out_strobe, f};
            default: out_word = out_reg;
        endcase
        bus.uo_out  = out_word[7:0];
        bus.uio_out = {out_word[11:8], 4'h0};
        bus.uio_oe  = 8'hF0;
        bus.phase   = ph;
    end

    // ALU; 13-bit intermediates give carry/borrow in bit 12
    logic [12:0] sum_ab, sum_abf, diff_ab, diff_ba, diff_abf;
    logic [11:0] alu;
    logic        alu_f;

    always_comb begin
        sum_ab   = {1'b0, a} + {1'b0, b};
        sum_abf  = sum_ab + {12'b0, f};
        diff_ab  = {1'b0, a} - {1'b0, b};
        diff_ba  = {1'b0, b} - {1'b0, a};
        diff_abf = diff_ab - {12'b0, f};
        alu      = a;
        alu_f    = f;
        case (alu_op)
            4'd0:  alu = a;
            4'd1:  alu = b;
            4'd2:  begin alu = sum_ab[11:0];   alu_f = sum_ab[12];   end
            4'd3:  begin alu = diff_ab[11:0];  alu_f = diff_ab[12];  end
            4'd4:  begin alu = diff_ba[11:0];  alu_f = diff_ba[12];  end
            4'd5:  alu = a & b;
            4'd6:  alu = a | b;
            4'd7:  alu = a ^ b;
            4'd8:  alu = ~a;
            4'd9:  begin alu = sum_abf[11:0];  alu_f = sum_abf[12];  end
            4'd10: begin alu = diff_abf[11:0]; alu_f = diff_abf[12]; end
            4'd11: alu = {a[10:0], 1'b0};
            4'd12: alu = {1'b0, a[11:1]};
            4'd13: alu = {a[11], a[11:1]};
            4'd14: alu = 12'd0 - a;
            default: alu = k;
        endcase
    end

    // Next architectural state; every condition reads pre-instruction values
    logic [11:0] a_n, b_n, c_n, d_n, out_n, c_dec;
    logic [7:0]  pc_n;
    logic        taken, strobe_n, in_read_n;

    always_comb begin
        c_dec = c - 12'd1;
        case (a_src)
            2'd0:    a_n = a;
            2'd1:    a_n = alu;
            2'd2:    a_n = in_word;
            default: a_n = k;
        endcase
        case (b_src)
            2'd0:    b_n = b;
            2'd1:    b_n = alu;
            2'd2:    b_n = a;
            default: b_n = k;
        endcase
        case (c_src)
            2'd0:    c_n = c;
            2'd1:    c_n = alu;
            2'd2:    c_n = b;
            default: c_n = in_word;
        endcase
        if (pc_op == 3'd6) c_n = c_dec;
        d_n = d_src ? alu : d;
        case (out_src)
            2'd0:    out_n = out_reg;
            2'd1:    out_n = alu;
            2'd2:    out_n = a;
            default: out_n = c;
        endcase
        case (pc_op)
            3'd1:    taken = 1'b1;
            3'd2:    taken = f;
            3'd3:    taken = ~f;
            3'd4:    taken = (a == 12'd0);
            3'd5:    taken = (a != 12'd0);
            3'd6:    taken = (c_dec != 12'd0);
            default: taken = 1'b0;
        endcase
        pc_n      = taken ? l : pc + 8'd1;
        strobe_n  = (out_src != 2'd0);
        in_read_n = (a_src == 2'd2) || ((c_src == 2'd3) && (pc_op != 3'd6));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a <= '0; b <= '0; c <= '0; d <= '0; out_reg <= '0;
            f <= 1'b0; pc <= '0; out_strobe <= 1'b0; in_read <= 1'b0;
            instr_lo <= '0; instr_mid <= '0; instr_hi <= '0;
        end else if (bus.ena) begin
            case (ph)
                PH0: instr_lo  <= in_word;
                PH1: instr_mid <= in_word;
                PH2: instr_hi  <= bus.ui_in;
                default: begin
                    a <= a_n; b <= b_n; c <= c_n; d <= d_n; out_reg <= out_n;
                    f <= alu_f; pc <= pc_n;
                    out_strobe <= strobe_n; in_read <= in_read_n;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_michael_bell_hovalaag.sv
// Bench for the HOVALAAG tile: instruction-level reference model, per-cycle
// readback compare, directed scenarios with literal expectations, random programs.
module tb_michael_bell_hovalaag;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    michael_bell_hovalaag_if bus ();

    michael_bell_hovalaag dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          m_a, m_b, m_c, m_d, m_out, m_f, m_pc, m_strobe, m_inrd, m_ph;
    logic [31:0] m_instr;
    logic [11:0] seen [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_exec(input logic [31:0] ins, input int inw);
        int op, asrc, bsrc, csrc, osrc, pcop, k, l, r, nf, cdec, take;
        op = int'(ins[31:28]); asrc = int'(ins[27:26]); bsrc = int'(ins[25:24]);
        csrc = int'(ins[23:22]); osrc = int'(ins[20:19]); pcop = int'(ins[18:16]);
        k = int'(ins[15:8]); l = int'(ins[7:0]);
        nf = m_f;
        case (op)
            0:  r = m_a;
            1:  r = m_b;
            2:  begin r = m_a + m_b;        nf = (r > 4095) ? 1 : 0; end
            3:  begin r = m_a - m_b;        nf = (m_a < m_b) ? 1 : 0; end
            4:  begin r = m_b - m_a;        nf = (m_b < m_a) ? 1 : 0; end
            5:  r = m_a & m_b;
            6:  r = m_a | m_b;
            7:  r = m_a ^ m_b;
            8:  r = ~m_a;
            9:  begin r = m_a + m_b + m_f;  nf = (r > 4095) ? 1 : 0; end
            10: begin r = m_a - m_b - m_f;  nf = (m_a < m_b + m_f) ? 1 : 0; end
            11: r = m_a * 2;
            12: r = m_a / 2;
            13: r = (m_a / 2) + (m_a & 'h800);
            14: r = -m_a;
            default: r = k;
        endcase
        r = r & 4095;
        cdec = (m_c + 4095) % 4096;
        case (pcop)
            1: take = 1;
            2: take = m_f;
            3: take = 1 - m_f;
            4: take = (m_a == 0) ? 1 : 0;
            5: take = (m_a != 0) ? 1 : 0;
            6: take = (cdec != 0) ? 1 : 0;
            default: take = 0;
        endcase
        m_strobe = (osrc != 0) ? 1 : 0;
        m_inrd   = (asrc == 2 || (csrc == 3 && pcop != 6)) ? 1 : 0;
        m_out    = (osrc == 1) ? r : (osrc == 2) ? m_a : (osrc == 3) ? m_c : m_out;
        m_pc     = take ? l : (m_pc + 1) % 256;
        m_d      = ins[21] ? r : m_d;
        begin
            int na, nb, nc;
            na = (asrc == 1) ? r : (asrc == 2) ? inw : (asrc == 3) ? k : m_a;
            nb = (bsrc == 1) ? r : (bsrc == 2) ? m_a : (bsrc == 3) ? k : m_b;
            nc = (csrc == 1) ? r : (csrc == 2) ? m_b : (csrc == 3) ? inw : m_c;
            if (pcop == 6) nc = cdec;
            m_a = na; m_b = nb; m_c = nc;
        end
        m_f = nf;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_a = 0; m_b = 0; m_c = 0; m_d = 0; m_out = 0; m_f = 0; m_pc = 0;
            m_strobe = 0; m_inrd = 0; m_ph = 0; m_instr = '0;
        end else if (bus.ena) begin
            case (m_ph)
                0: m_instr[11:0]  = {bus.uio_in[3:0], bus.ui_in};
                1: m_instr[23:12] = {bus.uio_in[3:0], bus.ui_in};
                2: m_instr[31:24] = bus.ui_in;
                default: model_exec(m_instr, int'({bus.uio_in[3:0], bus.ui_in}));
            endcase
            m_ph = (m_ph + 1) % 4;
        end
    end

    // Per-cycle compare of the readback pins against the model
    always @(negedge clk) begin
        int exp_w;
        case (m_ph)
            0:       exp_w = m_pc;
            1:       exp_w = m_inrd * 4 + m_strobe * 2 + m_f;
            default: exp_w = m_out;
        endcase
        check("readback", {20'b0, bus.uio_out[7:4], bus.uo_out}, exp_w);
        check("uio_out_low", {28'b0, bus.uio_out[3:0]}, 32'h0);
        check("uio_oe", {24'b0, bus.uio_oe}, 32'hF0);
        check("phase", {30'b0, bus.phase}, m_ph);
    end

    task automatic drive_phase(input int idx, input logic [11:0] w);
        bus.ui_in  = w[7:0];
        bus.uio_in = {4'($urandom_range(0, 15)), w[11:8]};
        #3;
        seen[idx] = {bus.uio_out[7:4], bus.uo_out};
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [11:0] inw);
        drive_phase(0, ins[11:0]);
        drive_phase(1, ins[23:12]);
        drive_phase(2, {4'($urandom_range(0, 15)), ins[31:24]});
        drive_phase(3, inw);
    endtask

    task automatic send_gated(input logic [31:0] ins, input logic [11:0] inw, input logic [11:0] exp_status);
        drive_phase(0, ins[11:0]);
        bus.ui_in  = ins[19:12];
        bus.uio_in = {4'h0, ins[23:20]};
        bus.ena    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #3;
            check("stall_status", {20'b0, bus.uio_out[7:4], bus.uo_out}, exp_status);
            check("stall_phase", {30'b0, bus.phase}, 32'd1);
            @(posedge clk); #1;
        end
        bus.ena = 1'b1;
        drive_phase(1, ins[23:12]);
        drive_phase(2, {4'h0, ins[31:24]});
        drive_phase(3, inw);
    endtask

    task automatic send_rand(input logic [31:0] ins, input logic [11:0] inw);
        logic [11:0] chunk [4];
        chunk[0] = ins[11:0]; chunk[1] = ins[23:12];
        chunk[2] = {4'($urandom_range(0, 15)), ins[31:24]}; chunk[3] = inw;
        for (int p = 0; p < 4; p++) begin
            while ($urandom_range(0, 3) == 0) begin
                bus.ena    = 1'b0;
                bus.ui_in  = 8'($urandom);
                bus.uio_in = 8'($urandom);
                @(posedge clk); #1;
            end
            bus.ena = 1'b1;
            drive_phase(p, chunk[p]);
        end
    endtask

    initial begin
        bus.ena = 1'b1; bus.ui_in = '0; bus.uio_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        send(32'h0, 12'h0);
        send(32'hF4002500, 12'h0);
        // Reset in the middle of phase 2
        drive_phase(0, 12'h000);
        drive_phase(1, 12'h100);
        bus.ui_in = 8'h24;
        #2 rst = 1'b1;
        #1;
        check("reset_out", {20'b0, bus.uio_out[7:4], bus.uo_out}, 32'h0);
        check("reset_oe", {24'b0, bus.uio_oe}, 32'hF0);
        check("reset_uio_low", {28'b0, bus.uio_out[3:0]}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        #1 check("post_reset_phase", {30'b0, bus.phase}, 32'd0);
        #1 check("post_reset_pc", {20'b0, bus.uio_out[7:4], bus.uo_out}, 32'h0);
        @(posedge clk); #1;
        // The partial instruction above was discarded: restart phase 0 cleanly
        rst = 1'b1; #1 rst = 1'b0;

        send(32'hF4002500, 12'h0);
        check("load_pc0", seen[0], 12'h000);
        send(32'h00100000, 12'h0);
        check("load_pc1", seen[0], 12'h001);
        send(32'h0, 12'h0);
        check("load_pc2", seen[0], 12'h002);
        check("load_status", seen[1], 12'h002);
        check("load_out", seen[2], 12'h025);

        send(32'h08000000, 12'hFFF);
        send(32'h03000100, 12'h0);
        send(32'h24080000, 12'h0);
        send(32'h0, 12'h0);
        check("carry_status", seen[1], 12'h003);
        check("carry_out", seen[2], 12'h000);

        send(32'h00010040, 12'h0);
        send(32'h0, 12'h0);
        check("jump_pc", seen[0], 12'h040);
        send(32'h000100FF, 12'h0);
        send(32'h0, 12'h0);
        check("wrap_pre", seen[0], 12'h0FF);
        send(32'h0, 12'h0);
        check("wrap_pc", seen[0], 12'h000);

        send(32'h00C00000, 12'h003);
        send(32'h00060010, 12'h0);
        check("loop_start", seen[0], 12'h002);
        send(32'h00060010, 12'h0);
        check("loop_jump1", seen[0], 12'h010);
        send(32'h00060010, 12'h0);
        check("loop_jump2", seen[0], 12'h010);
        send(32'h00180000, 12'h0);
        check("loop_fall", seen[0], 12'h011);

        send_gated(32'hF0087A00, 12'h0, 12'h003);
        check("gated_prev_out", seen[2], 12'h000);
        send(32'h0, 12'h0);
        check("gated_out", seen[2], 12'h07A);
        check("gated_status", seen[1], 12'h003);

        for (int n = 0; n < 300; n++) begin
            send_rand($urandom, 12'($urandom));
        end
        bus.ena = 1'b1;
        @(negedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
